// File: rtl/blur_pkg.sv
// Shared types and constants for the RGB444 streaming Gaussian blur.
// Holds the kernel-mode and FSM-state encodings, the 3x3 / 5x5 weight
// tables with their normalising shifts, window geometry and the default
// channel width.
package blur_pkg;

  localparam int CH_W_DEFAULT = 4;

  // Window geometry: one 5x5 window serves every mode, centre at [2][2].
  localparam int WIN   = 5;
  localparam int LINES = WIN - 1;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    K3     = 2'd1,
    K5     = 2'd2
  } blur_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } blur_state_t;

  // Weights sum to 32 and 64, so normalisation is a rounded right shift.
  localparam int W3 [3][3] = '{'{3, 4, 3}, '{4, 4, 4}, '{3, 4, 3}};
  localparam int W5 [5][5] = '{'{1, 2, 3, 2, 1},
                               '{2, 3, 4, 3, 2},
                               '{3, 4, 4, 4, 3},
                               '{2, 3, 4, 3, 2},
                               '{1, 2, 3, 2, 1}};
  localparam int W3_SHIFT = 5;
  localparam int W5_SHIFT = 6;

  // blur_level 2 and 3 both select the 5x5 kernel.
  function automatic blur_mode_t level_to_mode(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return BYPASS;
      2'd1:    return K3;
      default: return K5;
    endcase
  endfunction

endpackage

// File: rtl/blur_stream_if.sv
// Pixel stream bundle: valid beat, start-of-frame marker and packed {R,G,B}
// pixel. The producer uses the master modport, the consumer the slave one.
interface blur_stream_if
  import blur_pkg::*;
#(
  parameter int PIX_W = 3 * CH_W_DEFAULT
);
  logic             valid;
  logic             sof;
  logic [PIX_W-1:0] data;

  modport master (output valid, sof, data);
  modport slave  (input  valid, sof, data);
endinterface

// File: rtl/blur_line_window.sv
// Line buffering and 5x5 window for the blur filter.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   shift_en    advance the window by one pixel and write the line RAMs
//   zero_inj    replace the incoming pixel with zero (used while flushing)
//   pix_in      incoming raster pixel
//   win         window taps; win[4][4] is the newest pixel, win[0][*] the
//               oldest line
// Each line RAM is an exact IMG_WIDTH-pixel delay driven by a free-running
// pointer, so the window stays geometrically correct whatever frame
// alignment the top level is tracking.
module blur_line_window
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH = 320,
  parameter int PIX_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             zero_inj,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] win [WIN][WIN]
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [PIX_W-1:0] line_mem [LINES][IMG_WIDTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [PIX_W-1:0] col [WIN];
  logic [PIX_W-1:0] win_q [WIN][WIN];
  logic [PIX_W-1:0] win_d [WIN][WIN];

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first,
    // otherwise the synthesiser would infer a latch to hold it.
    col[WIN-1] = zero_inj ? '0 : pix_in;
    for (int l = 0; l < LINES; l++) begin
      col[LINES-1-l] = line_mem[l][ptr_q];
    end

    ptr_d = ptr_q;
    win_d = win_q;
    if (shift_en) begin
      ptr_d = (ptr_q == AW'(IMG_WIDTH - 1)) ? '0 : ptr_q + 1'b1;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WIN-1] = col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // NOTE: line RAMs and window taps carry no reset; their contents are
  // don't-care until refilled, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (shift_en) begin
      // Line l receives whatever line l-1 held one line earlier.
      for (int l = 0; l < LINES; l++) begin
        line_mem[l][ptr_q] <= col[WIN-1-l];
      end
    end
  end

  assign win = win_q;

endmodule

// File: rtl/blur_stream_filter.sv
// Streaming Gaussian blur for the RGB444 camera path.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   blur_level  kernel select (0 bypass, 1 3x3, 2/3 5x5), taken at in_sof
//   in_if       input pixel stream (slave): valid, sof, data
//   out_if      filtered pixel stream (master): valid, sof, data
//   overrun     sticky framing error, cleared only by reset
// Pipeline: window shift -> weighted sums -> round/mux into output register.
// The FSM fills 2*IMG_WIDTH+2 pixels before the first output, then flushes
// the same number with zeros after the last input so every input pixel
// produces exactly one output pixel.
module blur_stream_filter
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int CH_W       = CH_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    blur_level,
  blur_stream_if.slave  in_if,
  blur_stream_if.master out_if,
  output logic          overrun
);

  localparam int PIX_W     = 3 * CH_W;
  localparam int CW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FLUSH_LEN = 2 * IMG_WIDTH + 2;
  localparam int FW        = $clog2(FLUSH_LEN);
  localparam int A3_W      = CH_W + 6;
  localparam int A5_W      = CH_W + 7;
  localparam logic [A3_W-1:0] RND3 = A3_W'(1 << (W3_SHIFT - 1));
  localparam logic [A5_W-1:0] RND5 = A5_W'(1 << (W5_SHIFT - 1));

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FILL  = FILL;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FLUSH = FLUSH;

  logic [1:0]       state_q, state_d;
  blur_mode_t       mode_q, mode_d;
  logic [CW-1:0]    in_col_q, in_col_d;
  logic [RW-1:0]    in_row_q, in_row_d;
  logic [CW-1:0]    cc_q, cc_d;
  logic [RW-1:0]    cr_q, cr_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             overrun_q, overrun_d;

  logic             sof_beat, frame_start, shift_en, zero_inj, emit;
  logic             last_beat, edge3, edge5;
  blur_mode_t       sel1_d;

  logic [PIX_W-1:0] win [WIN][WIN];

  logic             v1_q, sof1_q, v2_q, sof2_q;
  blur_mode_t       sel1_q, sel2_q;
  logic [A3_W-1:0]  sum3 [3];
  logic [A5_W-1:0]  sum5 [3];
  logic [A3_W-1:0]  s3_q [3];
  logic [A5_W-1:0]  s5_q [3];
  logic [PIX_W-1:0] ctr2_q;

  logic             out_valid_q, out_sof_q;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  blur_line_window #(
    .IMG_WIDTH(IMG_WIDTH),
    .PIX_W    (PIX_W)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_en(shift_en),
    .zero_inj(zero_inj),
    .pix_in  (in_if.data),
    .win     (win)
  );

  assign sof_beat  = in_if.valid & in_if.sof;
  assign last_beat = (in_row_q == RW'(IMG_HEIGHT - 1)) && (in_col_q == CW'(IMG_WIDTH - 1));

  // Frame FSM and input-position counters.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    flush_cnt_d = flush_cnt_q;
    overrun_d   = overrun_q;
    shift_en    = 1'b0;
    zero_inj    = 1'b0;
    emit        = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        frame_start = sof_beat;
      end
      S_FILL, S_RUN: begin
        if (sof_beat) begin
          overrun_d   = 1'b1;
          frame_start = 1'b1;
        end else if (in_if.valid) begin
          shift_en = 1'b1;
          emit     = (state_q == S_RUN);
          if (in_col_q == CW'(IMG_WIDTH - 1)) begin
            in_col_d = '0;
            in_row_d = in_row_q + 1'b1;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
          // Beat (2,1) is index 2*IMG_WIDTH+1: the window centre reaches
          // pixel 0 on the next beat.
          if (state_q == S_FILL && in_row_q == RW'(2) && in_col_q == CW'(1)) begin
            state_d = S_RUN;
          end
          if (state_q == S_RUN && last_beat) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      default: begin
        if (sof_beat) begin
          overrun_d   = 1'b1;
          frame_start = 1'b1;
        end else begin
          overrun_d   = overrun_q | in_if.valid;
          shift_en    = 1'b1;
          zero_inj    = 1'b1;
          emit        = 1'b1;
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    // The sof pixel itself is pixel 0 of the new frame.
    if (frame_start) begin
      state_d  = S_FILL;
      mode_d   = level_to_mode(blur_level);
      shift_en = 1'b1;
      in_col_d = CW'(1);
      in_row_d = '0;
    end
  end

  // Centre coordinates of the pixel being emitted, for border decisions.
  always_comb begin
    cc_d = cc_q;
    cr_d = cr_q;
    if (frame_start) begin
      cc_d = '0;
      cr_d = '0;
    end else if (emit) begin
      if (cc_q == CW'(IMG_WIDTH - 1)) begin
        cc_d = '0;
        cr_d = cr_q + 1'b1;
      end else begin
        cc_d = cc_q + 1'b1;
      end
    end
  end

  // Any kernel tap outside the image forces pass-through of the centre.
  always_comb begin
    edge3 = (cr_q == '0) || (cr_q == RW'(IMG_HEIGHT - 1)) ||
            (cc_q == '0) || (cc_q == CW'(IMG_WIDTH - 1));
    edge5 = (cr_q < RW'(2)) || (cr_q > RW'(IMG_HEIGHT - 3)) ||
            (cc_q < CW'(2)) || (cc_q > CW'(IMG_WIDTH - 3));
    case (mode_q)
      K3:      sel1_d = edge3 ? BYPASS : K3;
      K5:      sel1_d = edge5 ? BYPASS : K5;
      default: sel1_d = BYPASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= BYPASS;
      in_col_q    <= '0;
      in_row_q    <= '0;
      cc_q        <= '0;
      cr_q        <= '0;
      flush_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      cc_q        <= cc_d;
      cr_q        <= cr_d;
      flush_cnt_q <= flush_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // One adder tree per colour channel; ch 0 is R (the top bits).
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      sum3[ch] = '0;
      sum5[ch] = '0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          sum5[ch] = sum5[ch] +
                     A5_W'(W5[r][c]) * A5_W'(win[r][c][(2-ch)*CH_W +: CH_W]);
        end
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          sum3[ch] = sum3[ch] +
                     A3_W'(W3[r][c]) * A3_W'(win[r+1][c+1][(2-ch)*CH_W +: CH_W]);
        end
      end
    end
  end

  // Weighted averages never exceed the channel maximum, so truncation to
  // CH_W bits after the rounding shift is exact.
  always_comb begin
    out_data_d = out_data_q;
    if (v2_q) begin
      for (int ch = 0; ch < 3; ch++) begin
        case (sel2_q)
          K3:      out_data_d[(2-ch)*CH_W +: CH_W] = CH_W'((s3_q[ch] + RND3) >> W3_SHIFT);
          K5:      out_data_d[(2-ch)*CH_W +: CH_W] = CH_W'((s5_q[ch] + RND5) >> W5_SHIFT);
          default: out_data_d[(2-ch)*CH_W +: CH_W] = ctr2_q[(2-ch)*CH_W +: CH_W];
        endcase
      end
    end
  end

  // Stage 1 sideband aligns with the window update; stage 2 with the sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      sof1_q      <= 1'b0;
      sel1_q      <= BYPASS;
      v2_q        <= 1'b0;
      sof2_q      <= 1'b0;
      sel2_q      <= BYPASS;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      v1_q        <= emit;
      sof1_q      <= emit && (cr_q == '0) && (cc_q == '0);
      sel1_q      <= sel1_d;
      v2_q        <= v1_q;
      sof2_q      <= sof1_q;
      sel2_q      <= sel1_q;
      out_valid_q <= v2_q;
      out_sof_q   <= v2_q & sof2_q;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    s3_q   <= sum3;
    s5_q   <= sum5;
    ctr2_q <= win[2][2];
  end

  assign out_if.valid = out_valid_q;
  assign out_if.sof   = out_sof_q;
  assign out_if.data  = out_data_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_blur_stream_filter.sv
// Scoreboard bench for blur_stream_filter on a 15x15 image. Expected pixels
// come from a direct 2-D convolution of the stimulus image and are queued
// before each frame is driven; a negedge monitor pops and compares.
module tb_blur_stream_filter;

  localparam int W      = 15;
  localparam int H      = 15;
  localparam int N      = W * H;
  localparam int PW     = 12;
  localparam int FILL_N = 2 * W + 2;
  localparam int BLANK  = 2 * W + 5 + 2;

  localparam int K3W [3][3] = '{'{3, 4, 3}, '{4, 4, 4}, '{3, 4, 3}};
  localparam int K5W [5][5] = '{'{1, 2, 3, 2, 1},
                                '{2, 3, 4, 3, 2},
                                '{3, 4, 4, 4, 3},
                                '{2, 3, 4, 3, 2},
                                '{1, 2, 3, 2, 1}};

  typedef struct {
    logic [11:0] data;
    logic        sof;
    logic        mark;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  blur_level = 2'd0;
  logic        overrun;

  blur_stream_if #(.PIX_W(PW)) in_if ();
  blur_stream_if #(.PIX_W(PW)) out_if ();

  blur_stream_filter #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .CH_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blur_level(blur_level),
    .in_if     (in_if),
    .out_if    (out_if),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          drive_cyc = 0;
  int          mark_drive_cyc = -1;
  int          first_out_cyc = -1;
  bit          sb_en = 1'b1;
  exp_t        sb_q [$];
  logic [11:0] img [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: weighted average over the kernel footprint, or the centre
  // pixel itself when the footprint leaves the image or in bypass.
  function automatic logic [11:0] ref_pixel(input int k, input int lvl);
    int r, c, rad, tot, acc, wt, px;
    logic [11:0] res;
    r   = k / W;
    c   = k % W;
    rad = (lvl == 0) ? 0 : (lvl == 1) ? 1 : 2;
    if (rad == 0 || r < rad || c < rad || r > H - 1 - rad || c > W - 1 - rad)
      return img[k];
    tot = (rad == 1) ? 32 : 64;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      acc = 0;
      for (int dy = -rad; dy <= rad; dy++) begin
        for (int dx = -rad; dx <= rad; dx++) begin
          wt  = (rad == 1) ? K3W[dy+1][dx+1] : K5W[dy+2][dx+2];
          px  = int'(img[(r + dy) * W + (c + dx)]);
          acc = acc + wt * ((px >> (4 * (2 - ch))) & 15);
        end
      end
      res = res | 12'(((acc + tot / 2) / tot) << (4 * (2 - ch)));
    end
    return res;
  endfunction

  task automatic push_frame(input int lvl, input int count, input bit mark);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      e.data = ref_pixel(k, lvl);
      e.sof  = (k == 0);
      e.mark = mark && (k == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [11:0] px, input logic sof);
    in_if.valid = 1'b1;
    in_if.sof   = sof;
    in_if.data  = px;
    drive_cyc   = cyc;
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.sof   = 1'b0;
  endtask

  // blur_level is scrambled after the sof beat: only the sof value counts.
  task automatic drive_frame(input int lvl, input int nbeats, input int gap_pct);
    blur_level = 2'(lvl);
    for (int k = 0; k < nbeats; k++) begin
      if (k > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct)
        idle($urandom_range(1, 3));
      beat(img[k], k == 0);
      if (k == 0) blur_level = 2'($urandom);
      if (k == FILL_N) mark_drive_cyc = drive_cyc;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) idle(1);
    check(name, sb_q.size(), 0);
  endtask

  task automatic run_frame(input int lvl, input int gap_pct, input string name);
    push_frame(lvl, N, 1'b0);
    drive_frame(lvl, N, gap_pct);
    idle(BLANK);
    drain(name);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) img[k] = 12'($urandom);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_en && out_if.valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%0h exp=none", out_if.data);
      end else begin
        e = sb_q.pop_front();
        check("pixel{sof,data}", {out_if.sof, out_if.data}, {e.sof, e.data});
        if (e.mark) first_out_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    in_if.valid = 1'b0;
    in_if.sof   = 1'b0;
    in_if.data  = '0;

    idle(3);
    @(negedge clk);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_sof", out_if.sof, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Bypass ramp: output equals input, first output latency checked.
    for (int k = 0; k < N; k++) img[k] = 12'(k);
    push_frame(0, N, 1'b1);
    drive_frame(0, N, 0);
    idle(BLANK);
    drain("drain_bypass");
    check("latency", first_out_cyc, mark_drive_cyc + 3);

    // Uniform 0xABC through the 5x5 kernel, with input gaps.
    for (int k = 0; k < N; k++) img[k] = 12'hABC;
    run_frame(2, 25, "drain_uniform");

    // Impulse at (7,7) through 3x3 then 5x5.
    for (int k = 0; k < N; k++) img[k] = 12'h000;
    img[7 * W + 7] = 12'hF00;
    run_frame(1, 0, "drain_imp3");
    run_frame(2, 15, "drain_imp5");

    // Border pass-through with 5x5 (level 3).
    fill_random();
    img[0]          = 12'h123;
    img[1 * W + 13] = 12'h456;
    run_frame(3, 10, "drain_border");

    // Random images in every mode.
    for (int lvl = 0; lvl < 4; lvl++) begin
      fill_random();
      run_frame(lvl, 30, "drain_random");
    end
    check("overrun_clean", overrun, 0);

    // sof at beat 100: partial frame emits 100-FILL_N outputs, then new frame.
    fill_random();
    push_frame(1, 100 - FILL_N, 1'b0);
    drive_frame(1, 100, 0);
    fill_random();
    run_frame(2, 10, "drain_restart");
    check("overrun_sof_midframe", overrun, 1);

    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("overrun_after_reset", overrun, 0);

    // Stray in_valid during FLUSH is dropped and flagged.
    fill_random();
    push_frame(2, N, 1'b0);
    drive_frame(2, N, 0);
    idle(5);
    beat(12'($urandom), 1'b0);
    idle(BLANK);
    drain("drain_flush_stray");
    check("overrun_flush_valid", overrun, 1);

    // Reset in the middle of RUN clears every output next cycle.
    sb_en = 1'b0;
    fill_random();
    drive_frame(1, 60, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_valid", out_if.valid, 0);
    check("midrun_rst_sof", out_if.sof, 0);
    check("midrun_rst_data", out_if.data, 0);
    check("midrun_rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_en = 1'b1;

    // Beats without sof after reset are ignored; a new sof restarts cleanly.
    for (int i = 0; i < 5; i++) beat(12'($urandom), 1'b0);
    idle(10);
    fill_random();
    run_frame(1, 20, "drain_recover");
    check("overrun_recover", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
